// File: rtl/axi_mem_responder.sv
// axi_mem_responder
//   AXI4 slave backed by an on-chip RAM of 2**MEM_WORDS_LOG2 64-bit words.
//   Serves cache line fills, write-backs and single-beat accesses. Read and write
//   paths are independent FSMs and never stall each other.
//
// Ports
//   clk, reset            : single rising-edge clock, synchronous active-high reset
//   s_axi_aw* / s_axi_w*  : write address / write data channels (inputs + ready)
//   s_axi_b*              : write response channel
//   s_axi_ar*             : read address channel
//   s_axi_r*              : read data channel
//
// Word index is addr[MEM_WORDS_LOG2+2:3]; upper address bits alias and *size is
// ignored (every beat is 8 bytes). INCR and FIXED bursts are served; WRAP and
// reserved bursts transfer their beats with SLVERR, reads return 0 and writes
// leave the RAM untouched.
module axi_mem_responder #(
    parameter int ID_WIDTH       = 13,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int MEM_WORDS_LOG2 = 12,
    parameter int READ_LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    // write address
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    // write data
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    // write response
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    // read address
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    // read data
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int IW    = MEM_WORDS_LOG2;
    localparam int DEPTH = 1 << IW;

    localparam logic [IW-1:0] IDX_ONE = 1;
    // Wait-state cycles remaining after the AR handshake edge, minus one.
    localparam logic [15:0] LAT_INIT = (READ_LATENCY >= 2) ? 16'(READ_LATENCY - 2) : 16'd0;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_WAIT  = 2'd1;
    localparam logic [1:0] R_BURST = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic unused_bits;
    assign unused_bits = ^{s_axi_awsize, s_axi_arsize,
                           s_axi_awaddr[ADDR_WIDTH-1:IW+3], s_axi_awaddr[2:0],
                           s_axi_araddr[ADDR_WIDTH-1:IW+3], s_axi_araddr[2:0]};

    // ------------------------------------------------------------------ read path
    logic [1:0]          r_state_q, r_state_d;
    logic [ID_WIDTH-1:0] r_id_q, r_id_d;
    logic [IW-1:0]       r_idx_q, r_idx_d;
    logic [7:0]          r_len_q, r_len_d;
    logic [7:0]          r_beat_q, r_beat_d;
    logic                r_fixed_q, r_fixed_d;
    logic                r_bad_q, r_bad_d;
    logic [15:0]         r_lat_q, r_lat_d;
    logic [DATA_WIDTH-1:0] r_data_q;

    logic          r_load;
    logic [IW-1:0] r_load_idx;
    logic          r_load_bad;
    logic          ar_hs, r_hs, r_last;

    assign s_axi_arready = (r_state_q == R_IDLE) && !reset;
    assign s_axi_rvalid  = (r_state_q == R_BURST);
    assign r_last        = (r_beat_q == r_len_q);
    assign s_axi_rlast   = s_axi_rvalid && r_last;
    assign s_axi_rid     = r_id_q;
    assign s_axi_rresp   = r_bad_q ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rdata   = r_data_q;

    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid && s_axi_rready;

    always_comb begin
        r_state_d  = r_state_q;
        r_id_d     = r_id_q;
        r_idx_d    = r_idx_q;
        r_len_d    = r_len_q;
        r_beat_d   = r_beat_q;
        r_fixed_d  = r_fixed_q;
        r_bad_d    = r_bad_q;
        r_lat_d    = r_lat_q;
        r_load     = 1'b0;
        r_load_idx = r_idx_q;
        r_load_bad = r_bad_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_id_d    = s_axi_arid;
                    r_idx_d   = s_axi_araddr[IW+2:3];
                    r_len_d   = s_axi_arlen;
                    r_beat_d  = 8'd0;
                    r_fixed_d = (s_axi_arburst == 2'b00);
                    r_bad_d   = s_axi_arburst[1];
                    if (READ_LATENCY <= 1) begin
                        r_state_d  = R_BURST;
                        r_load     = 1'b1;
                        r_load_idx = s_axi_araddr[IW+2:3];
                        r_load_bad = s_axi_arburst[1];
                    end else begin
                        r_state_d = R_WAIT;
                        r_lat_d   = LAT_INIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_lat_q == 16'd0) begin
                    r_state_d = R_BURST;
                    r_load    = 1'b1;
                end else begin
                    r_lat_d = r_lat_q - 16'd1;
                end
            end
            R_BURST: begin
                if (r_hs) begin
                    if (r_last) begin
                        r_state_d = R_IDLE;
                    end else begin
                        // Next beat is fetched on this same edge so there is no bubble.
                        r_idx_d    = r_fixed_q ? r_idx_q : r_idx_q + IDX_ONE;
                        r_beat_d   = r_beat_q + 8'd1;
                        r_load     = 1'b1;
                        r_load_idx = r_idx_d;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_fixed_q <= 1'b0;
            r_bad_q   <= 1'b0;
            r_lat_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_fixed_q <= r_fixed_d;
            r_bad_q   <= r_bad_d;
            r_lat_q   <= r_lat_d;
        end
    end

    // Synchronous RAM read: a write committed on the same edge is not seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_q <= '0;
        end else if (r_load) begin
            r_data_q <= r_load_bad ? '0 : mem[r_load_idx];
        end
    end

    // ----------------------------------------------------------------- write path
    logic [1:0]          w_state_q, w_state_d;
    logic [ID_WIDTH-1:0] w_id_q, w_id_d;
    logic [IW-1:0]       w_idx_q, w_idx_d;
    logic [7:0]          w_len_q, w_len_d;
    logic [7:0]          w_beat_q, w_beat_d;
    logic                w_fixed_q, w_fixed_d;
    logic                w_bad_q, w_bad_d;
    logic                w_err_q, w_err_d;
    logic [1:0]          w_bresp_q, w_bresp_d;

    logic aw_hs, w_hs, w_last_beat;

    assign s_axi_awready = (w_state_q == W_IDLE) && !reset;
    assign s_axi_wready  = (w_state_q == W_DATA) && !reset;
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bid     = w_id_q;
    assign s_axi_bresp   = w_bresp_q;

    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign w_last_beat = (w_beat_q == w_len_q);

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_fixed_d = w_fixed_q;
        w_bad_d   = w_bad_q;
        w_err_d   = w_err_q;
        w_bresp_d = w_bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_state_d = W_DATA;
                    w_id_d    = s_axi_awid;
                    w_idx_d   = s_axi_awaddr[IW+2:3];
                    w_len_d   = s_axi_awlen;
                    w_beat_d  = 8'd0;
                    w_fixed_d = (s_axi_awburst == 2'b00);
                    w_bad_d   = s_axi_awburst[1];
                    w_err_d   = 1'b0;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    // The beat count, not wlast, ends the burst; a mismatch only flags it.
                    if (s_axi_wlast != w_last_beat) begin
                        w_err_d = 1'b1;
                    end
                    if (w_last_beat) begin
                        w_state_d = W_RESP;
                        w_bresp_d = (w_bad_q || w_err_d) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_idx_d  = w_fixed_q ? w_idx_q : w_idx_q + IDX_ONE;
                        w_beat_d = w_beat_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_fixed_q <= 1'b0;
            w_bad_q   <= 1'b0;
            w_err_q   <= 1'b0;
            w_bresp_q <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_fixed_q <= w_fixed_d;
            w_bad_q   <= w_bad_d;
            w_err_q   <= w_err_d;
            w_bresp_q <= w_bresp_d;
        end
    end

    // RAM is never cleared by reset; bad-burst writes are discarded.
    always_ff @(posedge clk) begin
        if (!reset && w_hs && !w_bad_q) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi_wstrb[i]) begin
                    mem[w_idx_q][8*i +: 8] <= s_axi_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder (default parameters,
// READ_LATENCY = 2). Inputs change and outputs are sampled 1 ns after each
// rising edge.
module tb_axi_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] awid, arid, bid, rid;
    logic [63:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [12:0] rd_id   [16];
    int          rd_cnt;

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .clk(clk), .reset(reset),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [63:0] addr, input logic [7:0] len,
                             input logic [12:0] id, input logic [1:0] burst,
                             input logic [63:0] base, input logic [7:0] strb,
                             input logic [15:0] lastmask,
                             output logic [1:0] resp, output logic [12:0] id_o);
        int t;
        resp = 2'bxx;
        id_o = 'x;
        awaddr = addr; awlen = len; awid = id; awburst = burst; awsize = 3'd3;
        awvalid = 1'b1;
        t = 0;
        while (!awready && t < 20) begin step(); t++; end
        step();
        awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            wdata = base + 64'(k); wstrb = strb; wlast = lastmask[k]; wvalid = 1'b1;
            while (!wready && t < 40) begin step(); t++; end
            step();
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        while (!bvalid && t < 60) begin step(); t++; end
        n_tests++;
        if (!bvalid) begin
            n_fail++;
            $display("FAIL write_timeout: bvalid=%0b required 1", bvalid);
        end else begin
            resp = bresp;
            id_o = bid;
        end
        step();
        bready = 1'b0;
    endtask

    task automatic ar_send(input logic [63:0] addr, input logic [7:0] len,
                           input logic [12:0] id, input logic [1:0] burst, output int lat);
        int t;
        araddr = addr; arlen = len; arid = id; arburst = burst; arsize = 3'd3;
        arvalid = 1'b1;
        t = 0;
        while (!arready && t < 20) begin step(); t++; end
        step();
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 50) begin step(); lat++; end
    endtask

    task automatic r_collect(input int n);
        int t;
        rd_cnt = 0;
        rready = 1'b1;
        t = 0;
        while (rd_cnt < n && t < 200) begin
            if (rvalid) begin
                rd_data[rd_cnt] = rdata; rd_resp[rd_cnt] = rresp;
                rd_last[rd_cnt] = rlast; rd_id[rd_cnt]   = rid;
                rd_cnt++;
            end
            step();
            t++;
        end
        rready = 1'b0;
        n_tests++;
        if (rd_cnt != n) begin
            n_fail++;
            $display("FAIL read_timeout: beats=%0d required %0d", rd_cnt, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = 2'b01;
        wdata = '0; wstrb = '0; wlast = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = 2'b01;
        repeat (3) step();
        n_tests++;
        if ({arready, awready, wready, rvalid, bvalid, rlast} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: ar/aw/w/rv/bv/rlast=%b required 000000",
                     {arready, awready, wready, rvalid, bvalid, rlast});
        end
        n_tests++;
        if ({rid, bid, rresp, bresp, rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: rid=%h bid=%h rresp=%b bresp=%b rdata=%h required 0",
                     rid, bid, rresp, bresp, rdata);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({arready, awready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release: arready/awready=%b required 11", {arready, awready});
        end
    endtask

    task automatic test_single();
        logic [1:0]  resp;
        logic [12:0] id;
        int          lat;
        axi_write(64'h100, 8'd0, 13'd5, 2'b01, 64'h1122334455667788, 8'hFF, 16'h1, resp, id);
        n_tests++;
        if (resp !== 2'b00 || id !== 13'd5) begin
            n_fail++;
            $display("FAIL single_b: bresp=%b bid=%0d required 00/5", resp, id);
        end
        ar_send(64'h100, 8'd0, 13'd7, 2'b01, lat);
        n_tests++;
        if (lat != 2) begin
            n_fail++;
            $display("FAIL single_latency: %0d cycles required 2", lat);
        end
        r_collect(1);
        n_tests++;
        if (rd_data[0] !== 64'h1122334455667788 || rd_id[0] !== 13'd7 ||
            rd_last[0] !== 1'b1 || rd_resp[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL single_r: data=%h id=%0d last=%b resp=%b required 1122334455667788/7/1/00",
                     rd_data[0], rd_id[0], rd_last[0], rd_resp[0]);
        end
    endtask

    task automatic test_incr_stall();
        logic [1:0]  resp;
        logic [12:0] id;
        logic [63:0] held_d;
        logic        held_l;
        logic        stalled;
        int          lat, n, cyc;
        axi_write(64'h200, 8'd3, 13'd1, 2'b01, 64'hA0, 8'hFF, 16'h8, resp, id);
        n_tests++;
        if (resp !== 2'b00) begin
            n_fail++;
            $display("FAIL incr_b: bresp=%b required 00", resp);
        end
        ar_send(64'h200, 8'd3, 13'd2, 2'b01, lat);
        n = 0; cyc = 0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
        while (n < 4 && cyc < 60) begin
            rready = (cyc % 2 == 0);
            if (rvalid) begin
                if (stalled) begin
                    n_tests++;
                    if (rdata !== held_d || rlast !== held_l) begin
                        n_fail++;
                        $display("FAIL incr_stall_hold: data=%h last=%b required %h/%b",
                                 rdata, rlast, held_d, held_l);
                    end
                    stalled = 1'b0;
                end
                if (rready) begin
                    n_tests++;
                    if (rdata !== 64'hA0 + 64'(n) || rlast !== (n == 3)) begin
                        n_fail++;
                        $display("FAIL incr_beat%0d: data=%h last=%b required %h/%b",
                                 n, rdata, rlast, 64'hA0 + 64'(n), (n == 3));
                    end
                    n++;
                end else begin
                    stalled = 1'b1; held_d = rdata; held_l = rlast;
                end
            end
            step();
            cyc++;
        end
        rready = 1'b0;
        n_tests++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL incr_count: beats=%0d required 4", n);
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  resp;
        logic [12:0] id;
        int          lat;
        axi_write(64'h300, 8'd0, 13'd1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 16'h1, resp, id);
        axi_write(64'h300, 8'd0, 13'd1, 2'b01, 64'h0, 8'h0F, 16'h1, resp, id);
        ar_send(64'h300, 8'd0, 13'd1, 2'b01, lat);
        r_collect(1);
        n_tests++;
        if (rd_data[0] !== 64'hFFFF_FFFF_0000_0000) begin
            n_fail++;
            $display("FAIL strobe: data=%h required ffffffff00000000", rd_data[0]);
        end
    endtask

    task automatic test_bad_burst();
        logic [1:0]  resp;
        logic [12:0] id;
        int          lat;
        ar_send(64'h100, 8'd1, 13'd4, 2'b10, lat);
        r_collect(2);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (rd_resp[k] !== 2'b10 || rd_data[k] !== 64'h0 || rd_last[k] !== (k == 1)) begin
                n_fail++;
                $display("FAIL wrap_read%0d: resp=%b data=%h last=%b required 10/0/%b",
                         k, rd_resp[k], rd_data[k], rd_last[k], (k == 1));
            end
        end
        axi_write(64'h100, 8'd0, 13'd6, 2'b10, 64'hDEAD, 8'hFF, 16'h1, resp, id);
        n_tests++;
        if (resp !== 2'b10) begin
            n_fail++;
            $display("FAIL wrap_write_b: bresp=%b required 10", resp);
        end
        ar_send(64'h100, 8'd0, 13'd4, 2'b01, lat);
        r_collect(1);
        n_tests++;
        if (rd_data[0] !== 64'h1122334455667788 || rd_resp[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL wrap_ram_kept: data=%h resp=%b required 1122334455667788/00",
                     rd_data[0], rd_resp[0]);
        end
    endtask

    task automatic test_wlast_err();
        logic [1:0]  resp;
        logic [12:0] id;
        int          lat;
        axi_write(64'h500, 8'd2, 13'd8, 2'b01, 64'h50, 8'hFF, 16'b010, resp, id);
        n_tests++;
        if (resp !== 2'b10 || id !== 13'd8 || wready !== 1'b0) begin
            n_fail++;
            $display("FAIL wlast_err: bresp=%b bid=%0d wready=%b required 10/8/0", resp, id, wready);
        end
        ar_send(64'h500, 8'd2, 13'd8, 2'b01, lat);
        r_collect(3);
        n_tests++;
        if (rd_data[0] !== 64'h50 || rd_data[1] !== 64'h51 || rd_data[2] !== 64'h52) begin
            n_fail++;
            $display("FAIL wlast_data: %h %h %h required 50 51 52",
                     rd_data[0], rd_data[1], rd_data[2]);
        end
    endtask

    task automatic test_fixed_alias();
        logic [1:0]  resp;
        logic [12:0] id;
        int          lat;
        axi_write(64'h400, 8'd1, 13'd2, 2'b00, 64'h11, 8'hFF, 16'h2, resp, id);
        ar_send(64'h400, 8'd0, 13'd2, 2'b01, lat);
        r_collect(1);
        n_tests++;
        if (rd_data[0] !== 64'h12 || resp !== 2'b00) begin
            n_fail++;
            $display("FAIL fixed_write: data=%h bresp=%b required 12/00", rd_data[0], resp);
        end
        // Bit 15 is above the index and bits [2:0] are below it: both ignored.
        ar_send(64'h8105, 8'd1, 13'd3, 2'b00, lat);
        r_collect(2);
        n_tests++;
        if (rd_data[0] !== 64'h1122334455667788 || rd_data[1] !== 64'h1122334455667788 ||
            rd_last[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL fixed_alias_read: %h %h last=%b required 1122334455667788 x2, 1",
                     rd_data[0], rd_data[1], rd_last[1]);
        end
    endtask

    task automatic test_reset_mid_burst();
        int lat;
        ar_send(64'h200, 8'd7, 13'd9, 2'b01, lat);
        r_collect(4);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (rd_data[k] !== 64'hA0 + 64'(k) || rd_last[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_beat%0d: data=%h last=%b required %h/0",
                         k, rd_data[k], rd_last[k], 64'hA0 + 64'(k));
            end
        end
        reset = 1'b1;
        step();
        n_tests++;
        if (rvalid !== 1'b0 || arready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: rvalid=%b arready=%b required 0/0", rvalid, arready);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (arready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_release: arready=%b required 1", arready);
        end
        ar_send(64'h300, 8'd0, 13'd3, 2'b01, lat);
        r_collect(1);
        n_tests++;
        if (rd_data[0] !== 64'hFFFF_FFFF_0000_0000 || rd_id[0] !== 13'd3 ||
            rd_last[0] !== 1'b1 || lat != 2) begin
            n_fail++;
            $display("FAIL mid_new_read: data=%h id=%0d last=%b lat=%0d required ffffffff00000000/3/1/2",
                     rd_data[0], rd_id[0], rd_last[0], lat);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_incr_stall();
        test_strobe();
        test_bad_burst();
        test_wlast_err();
        test_fixed_alias();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 slave (responder) backed by an on-chip word-addressed RAM.
- Answers the core's m_axi read/write channels: cache line fills, write-backs and single-beat accesses.
- Used as the memory end of the bus in standalone core simulation and FPGA bring-up.
- Read and write paths are independent FSMs. Snoop (ac*) channels are out of scope.

Parameters:
- ID_WIDTH, 13: width of AXI ID fields.
- ADDR_WIDTH, 64: width of AXI address.
- DATA_WIDTH, 64: beat width; fixed at 64 in this block.
- STRB_WIDTH, DATA_WIDTH/8: byte strobes per beat.
- MEM_WORDS_LOG2, 12: log2 of RAM depth in 64-bit words.
- READ_LATENCY, 2: cycles from AR handshake to first rvalid (minimum 1).

Ports:
- clk in 1: single clock, all logic rising-edge.
- reset in 1: synchronous, active-high.
- s_axi_awid/awaddr/awlen/awsize/awburst in ID_WIDTH/ADDR_WIDTH/8/3/2: write address.
- s_axi_awvalid in 1; s_axi_awready out 1.
- s_axi_wdata/wstrb/wlast in DATA_WIDTH/STRB_WIDTH/1: write data.
- s_axi_wvalid in 1; s_axi_wready out 1.
- s_axi_bid/bresp out ID_WIDTH/2: write response.
- s_axi_bvalid out 1; s_axi_bready in 1.
- s_axi_arid/araddr/arlen/arsize/arburst in ID_WIDTH/ADDR_WIDTH/8/3/2: read address.
- s_axi_arvalid in 1; s_axi_arready out 1.
- s_axi_rid/rdata/rresp/rlast out ID_WIDTH/DATA_WIDTH/2/1: read data.
- s_axi_rvalid out 1; s_axi_rready in 1.

Behaviour:
- Reset (clk edge with reset=1):
  - All valid/ready outputs 0; rid/bid/rresp/bresp/rlast/rdata 0.
  - Both FSMs go to IDLE. Any in-flight burst is dropped with no response.
  - RAM contents are not cleared.
  - arready=1 and awready=1 from the first cycle after reset deasserts.
- Addressing:
  - Word index = addr[MEM_WORDS_LOG2+2:3]. Bits [2:0] ignored. Upper bits ignored (aliasing).
  - Index wraps modulo depth.
  - arsize/awsize ignored; every beat is 8 bytes.
- Burst type:
  - INCR (01): index +1 per beat.
  - FIXED (00): index constant.
  - WRAP (10) and reserved (11): beats still transferred; resp=SLVERR (2'b10); reads return 0; writes have no RAM effect.
  - Otherwise resp=OKAY (2'b00).
- Read FSM R_IDLE -> R_WAIT -> R_BURST:
  - R_IDLE: arready=1. On arvalid&arready, capture arid, index, arlen, burst; beat counter=0; load latency counter; go to R_WAIT.
  - R_WAIT: arready=0. Count down READ_LATENCY-1 cycles, then go to R_BURST with rvalid=1.
  - R_BURST: rvalid=1, rid=captured ID, rlast=(beat==arlen). rdata/rresp/rlast held stable while rready=0.
  - On rvalid&rready: if not last, advance index/beat and present next beat the next cycle (no bubble); if last, go to R_IDLE (arready=1 next cycle).
  - Throughput: 1 beat/cycle. AR-to-first-beat = READ_LATENCY cycles.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1, wready=0. On AW handshake, capture awid, index, awlen, burst; beat=0; go to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready writes byte i of RAM[index] iff wstrb[i].
  - Burst ends on beat==awlen regardless of wlast. If wlast≠(beat==awlen) on any beat, the error flag is set and bresp=SLVERR.
  - W data arriving before the AW handshake waits (wready=0).
  - W_RESP: bvalid=1, bid=captured ID; held until bready, then go to W_IDLE.
- Read/write collision:
  - rdata is registered from the RAM at the edge that makes a beat valid (or advances to it).
  - A write to the same word committed at that same edge is not visible (old data).
  - Later beats see the new data.
- Read and write channels never stall each other.

Test Plan:
- Write AW addr=0x100 len=0 id=5, W data=0x1122334455667788 strb=0xFF wlast=1; then AR addr=0x100 len=0 id=7 -> bresp=00 bid=5; rvalid exactly 2 cycles after AR handshake, rdata=0x1122334455667788, rid=7, rlast=1.
- Write 4-beat INCR at 0x200 (data k=0..3 = 0xA0+k), then read 4-beat INCR at 0x200 with rready toggling 1,0,1,0 -> beats 0xA0..0xA3 in order, data stable during stalls, rlast only on 4th.
- Write word 0x300=0xFFFF...FF, then write strb=0x0F data=0 -> read returns 0xFFFFFFFF00000000.
- Read with arburst=2'b10 len=1 -> two beats, rresp=10, rdata=0; RAM unchanged.
- Write len=2 with wlast asserted on beat 1 -> three beats accepted, bresp=10.
- Reset asserted mid 8-beat read (after beat 3) -> rvalid=0 next cycle, arready=1 after deassert; new read id=3 completes normally.
